// File: rtl/fu_issue_scheduler_pkg.sv
// rtl/fu_issue_scheduler_pkg.sv - shared types and constants for the issue scheduler
// Contents: fu_idx_t (functional unit index), sched_state_t (halt FSM state),
//           NUM_FU / NUM_REGS defaults.
package fu_issue_scheduler_pkg;

    localparam int NUM_FU   = 4;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        FU_ARITH = 2'd0,
        FU_MULT  = 2'd1,
        FU_DIV   = 2'd2,
        FU_LSU   = 2'd3
    } fu_idx_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fu_issue_scheduler_rr_arbiter.sv
// rtl/fu_issue_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req         in  N  request vector
//   ptr         in  W  highest-priority index this cycle
//   grant       out N  one-hot grant (zero when no request)
//   grant_idx   out W  index of the granted requester (0 when none)
//   grant_valid out 1  a request was granted
module fu_issue_scheduler_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] idx;

    // Walk the requesters starting at ptr and wrapping; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// rtl/fu_issue_scheduler.sv - hazard-checked issue and round-robin writeback scheduler
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   issue_valid/fu/rs1/rs2/rd/wen  decoded instruction from the control unit
//   issue_ready                    instruction accepted this cycle
//   flush                          suppress issue this cycle
//   halt_req                       current instruction is a halt
//   fu_start                       one-hot start pulse to the target unit
//   fu_done                        per-unit result pending (held until acked)
//   fu_ack                         one-hot writeback grant
//   wb_valid/wb_rd/wb_fu           register-file write port control
//   halted                         all units drained, core halted
module fu_issue_scheduler
    import fu_issue_scheduler_pkg::*;
#(
    parameter int NUM_FU   = 4,
    parameter int NUM_REGS = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              issue_valid,
    input  fu_idx_t           issue_fu,
    input  logic [4:0]        issue_rs1,
    input  logic [4:0]        issue_rs2,
    input  logic [4:0]        issue_rd,
    input  logic              issue_wen,
    output logic              issue_ready,
    input  logic              flush,
    input  logic              halt_req,
    output logic [NUM_FU-1:0] fu_start,
    input  logic [NUM_FU-1:0] fu_done,
    output logic [NUM_FU-1:0] fu_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output fu_idx_t           wb_fu,
    output logic              halted
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_REGS-1:0] reg_busy;
    logic [NUM_FU-1:0]   fu_busy;
    logic [NUM_FU-1:0]   fu_wen;
    logic [4:0]          fu_rd [NUM_FU];
    logic [PTR_W-1:0]    rr_ptr;
    sched_state_t        state;

    logic [NUM_FU-1:0]   grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [NUM_FU-1:0]   wb_req;

    logic [NUM_FU-1:0]   fu_busy_nx;
    logic [NUM_REGS-1:0] reg_busy_nx;
    logic [NUM_REGS-1:0] reg_clr;
    logic [NUM_REGS-1:0] reg_set;
    logic                raw;
    logic                waw;
    logic                fu_hold;

    // A done flag from an idle unit is never a candidate.
    assign wb_req = fu_done & fu_busy;

    fu_issue_scheduler_rr_arbiter #(
        .N (NUM_FU),
        .W (PTR_W)
    ) u_wb_arb (
        .req         (wb_req),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        fu_ack   = grant;
        wb_fu    = fu_idx_t'(grant_idx);
        wb_rd    = grant_valid ? fu_rd[grant_idx] : 5'd0;
        wb_valid = grant_valid && fu_wen[grant_idx] && (fu_rd[grant_idx] != 5'd0);

        // Only a real register write releases the scoreboard bit; a non-writing
        // op that happens to carry an rd must not free another op's claim.
        reg_clr = '0;
        if (wb_valid) begin
            reg_clr[fu_rd[grant_idx]] = 1'b1;
        end

        // Hazards are evaluated against the post-writeback view so a consumer
        // can issue in the same cycle its producer is acked.
        fu_busy_nx  = fu_busy & ~grant;
        reg_busy_nx = reg_busy & ~reg_clr;

        raw     = ((issue_rs1 != 5'd0) && reg_busy_nx[issue_rs1]) ||
                  ((issue_rs2 != 5'd0) && reg_busy_nx[issue_rs2]);
        waw     = issue_wen && (issue_rd != 5'd0) && reg_busy_nx[issue_rd];
        fu_hold = fu_busy_nx[issue_fu];

        // The halt instruction itself is consumed by the FSM, never issued.
        issue_ready = issue_valid && !flush && !halt_req && (state == ST_RUN) &&
                      !raw && !waw && !fu_hold;

        fu_start = '0;
        if (issue_ready) begin
            fu_start[issue_fu] = 1'b1;
        end

        reg_set = '0;
        if (issue_ready && issue_wen && (issue_rd != 5'd0)) begin
            reg_set[issue_rd] = 1'b1;
        end
    end

    // Scoreboard and per-unit tracking; set is OR-ed after clear so a
    // same-cycle turnover on one unit/register keeps the new claim.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            reg_busy <= '0;
            fu_busy  <= '0;
            fu_wen   <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                fu_rd[i] <= 5'd0;
            end
        end else begin
            fu_busy  <= fu_busy_nx | fu_start;
            reg_busy <= reg_busy_nx | reg_set;
            if (grant_valid) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            if (issue_ready) begin
                fu_rd[issue_fu]  <= issue_rd;
                fu_wen[issue_fu] <= issue_wen;
            end
        end
    end

    // Halt sequencing: stop issuing, wait for every unit to retire, then park.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req && issue_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fu_busy_nx == '0) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb/tb_fu_issue_scheduler.sv - directed self-checking bench for fu_issue_scheduler
module tb_fu_issue_scheduler;
    import fu_issue_scheduler_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       issue_valid;
    fu_idx_t    issue_fu;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic       issue_wen;
    logic       issue_ready;
    logic       flush;
    logic       halt_req;
    logic [3:0] fu_start;
    logic [3:0] fu_done;
    logic [3:0] fu_ack;
    logic       wb_valid;
    logic [4:0] wb_rd;
    fu_idx_t    wb_fu;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    fu_issue_scheduler dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .issue_valid (issue_valid),
        .issue_fu    (issue_fu),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .issue_ready (issue_ready),
        .flush       (flush),
        .halt_req    (halt_req),
        .fu_start    (fu_start),
        .fu_done     (fu_done),
        .fu_ack      (fu_ack),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_fu       (wb_fu),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input fu_idx_t fu, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
        issue_valid = v;
        issue_fu    = fu;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_wen   = wen;
    endtask

    task automatic do_reset;
        nRST     = 1'b0;
        drive(1'b0, FU_ARITH, 5'd0, 5'd0, 5'd0, 1'b0);
        flush    = 1'b0;
        halt_req = 1'b0;
        fu_done  = 4'b0000;
        #2;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        nRST     = 1'b0;
        drive(1'b0, FU_ARITH, 5'd0, 5'd0, 5'd0, 1'b0);
        flush    = 1'b0;
        halt_req = 1'b0;
        fu_done  = 4'b0000;
        #3;
        check("rst_issue_ready", issue_ready, 1'b0);
        check("rst_fu_start", fu_start, 4'b0000);
        check("rst_fu_ack", fu_ack, 4'b0000);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fu_busy", dut.fu_busy, 4'b0000);
        check("rst_reg_busy", dut.reg_busy, 32'h0);
        check("rst_rr_ptr", dut.rr_ptr, 2'd0);
        check("rst_state", dut.state, ST_RUN);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // 1: RAW stall on a DIV result, consumer issues in the ack cycle
        drive(1'b1, FU_DIV, 5'd1, 5'd2, 5'd5, 1'b1);
        #1;
        check("t1_div_ready", issue_ready, 1'b1);
        check("t1_div_start", fu_start, 4'b0100);
        tick();
        drive(1'b1, FU_ARITH, 5'd5, 5'd0, 5'd6, 1'b1);
        #1;
        check("t1_raw_ready", issue_ready, 1'b0);
        check("t1_raw_start", fu_start, 4'b0000);
        check("t1_reg_busy5", dut.reg_busy, 32'h0000_0020);
        tick();
        check("t1_raw_ready2", issue_ready, 1'b0);
        tick();
        fu_done = 4'b0100;
        #1;
        check("t1_ack", fu_ack, 4'b0100);
        check("t1_wb_valid", wb_valid, 1'b1);
        check("t1_wb_rd", wb_rd, 5'd5);
        check("t1_wb_fu", wb_fu, FU_DIV);
        check("t1_ready_in_ack", issue_ready, 1'b1);
        check("t1_start_in_ack", fu_start, 4'b0001);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b0000;
        #1;
        check("t1_fu_busy", dut.fu_busy, 4'b0001);
        check("t1_reg_busy6", dut.reg_busy, 32'h0000_0040);
        check("t1_rr_ptr", dut.rr_ptr, 2'd3);
        fu_done = 4'b0001;
        #1;
        check("t1_arith_ack", fu_ack, 4'b0001);
        check("t1_arith_rd", wb_rd, 5'd6);
        tick();
        fu_done = 4'b0000;
        #1;
        check("t1_end_busy", dut.fu_busy, 4'b0000);
        check("t1_end_regs", dut.reg_busy, 32'h0);
        check("t1_end_ptr", dut.rr_ptr, 2'd1);

        do_reset();

        // 2: round-robin among MULT, DIV, LSU from rr_ptr=0
        drive(1'b1, FU_MULT, 5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        check("t2_mult_start", fu_start, 4'b0010);
        tick();
        drive(1'b1, FU_DIV, 5'd0, 5'd0, 5'd8, 1'b1);
        #1;
        check("t2_div_start", fu_start, 4'b0100);
        tick();
        drive(1'b1, FU_LSU, 5'd0, 5'd0, 5'd9, 1'b1);
        #1;
        check("t2_lsu_start", fu_start, 4'b1000);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b1110;
        #1;
        check("t2_ack1", fu_ack, 4'b0010);
        check("t2_rd1", wb_rd, 5'd7);
        check("t2_fu1", wb_fu, FU_MULT);
        tick();
        fu_done = 4'b1100;
        #1;
        check("t2_ack2", fu_ack, 4'b0100);
        check("t2_rd2", wb_rd, 5'd8);
        tick();
        fu_done = 4'b1000;
        #1;
        check("t2_ack3", fu_ack, 4'b1000);
        check("t2_rd3", wb_rd, 5'd9);
        check("t2_fu3", wb_fu, FU_LSU);
        tick();
        fu_done = 4'b0000;
        #1;
        check("t2_ptr", dut.rr_ptr, 2'd0);
        check("t2_busy", dut.fu_busy, 4'b0000);
        check("t2_regs", dut.reg_busy, 32'h0);

        // 3: x0 destination and non-writing op never stall or write back
        drive(1'b1, FU_MULT, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check("t3_mult_ready", issue_ready, 1'b1);
        tick();
        drive(1'b1, FU_ARITH, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("t3_regs_zero", dut.reg_busy, 32'h0);
        check("t3_arith_ready", issue_ready, 1'b1);
        check("t3_arith_start", fu_start, 4'b0001);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b0011;
        #1;
        check("t3_ack_arith", fu_ack, 4'b0001);
        check("t3_wbv_nowen", wb_valid, 1'b0);
        tick();
        fu_done = 4'b0010;
        #1;
        check("t3_ack_mult", fu_ack, 4'b0010);
        check("t3_wbv_x0", wb_valid, 1'b0);
        tick();
        fu_done = 4'b0000;
        #1;
        check("t3_regs_end", dut.reg_busy, 32'h0);
        check("t3_ptr", dut.rr_ptr, 2'd2);

        // 4: structural stall on MULT, turnover in the ack cycle
        drive(1'b1, FU_MULT, 5'd0, 5'd0, 5'd10, 1'b1);
        #1;
        check("t4_first_start", fu_start, 4'b0010);
        tick();
        drive(1'b1, FU_MULT, 5'd0, 5'd0, 5'd11, 1'b1);
        #1;
        check("t4_struct_stall", issue_ready, 1'b0);
        tick();
        check("t4_struct_stall2", issue_ready, 1'b0);
        fu_done = 4'b0010;
        #1;
        check("t4_ack", fu_ack, 4'b0010);
        check("t4_wb_rd", wb_rd, 5'd10);
        check("t4_turn_ready", issue_ready, 1'b1);
        check("t4_turn_start", fu_start, 4'b0010);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b0000;
        #1;
        check("t4_fu_busy", dut.fu_busy, 4'b0010);
        check("t4_reg_busy", dut.reg_busy, 32'h0000_0800);
        check("t4_fu_rd", dut.fu_rd[1], 5'd11);
        // ARITH claims rd=11 in the same cycle MULT releases it
        fu_done = 4'b0010;
        drive(1'b1, FU_ARITH, 5'd0, 5'd0, 5'd11, 1'b1);
        #1;
        check("t4_waw_clear_ready", issue_ready, 1'b1);
        check("t4_waw_start", fu_start, 4'b0001);
        check("t4_ack2", fu_ack, 4'b0010);
        check("t4_wb_rd2", wb_rd, 5'd11);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b0000;
        #1;
        check("t4_set_wins", dut.reg_busy, 32'h0000_0800);
        check("t4_busy_arith", dut.fu_busy, 4'b0001);
        check("t4_ptr", dut.rr_ptr, 2'd2);
        fu_done = 4'b0001;
        #1;
        check("t4_ack3", fu_ack, 4'b0001);
        tick();
        fu_done = 4'b0000;
        #1;
        check("t4_ptr_end", dut.rr_ptr, 2'd1);
        check("t4_regs_end", dut.reg_busy, 32'h0);

        // 5: halt drain with an LSU op in flight
        drive(1'b1, FU_LSU, 5'd0, 5'd0, 5'd12, 1'b1);
        #1;
        check("t5_lsu_start", fu_start, 4'b1000);
        tick();
        drive(1'b1, FU_ARITH, 5'd0, 5'd0, 5'd0, 1'b0);
        halt_req = 1'b1;
        #1;
        check("t5_halt_not_issued", issue_ready, 1'b0);
        check("t5_halt_start", fu_start, 4'b0000);
        tick();
        halt_req = 1'b0;
        #1;
        check("t5_state_drain", dut.state, ST_DRAIN);
        check("t5_drain_ready", issue_ready, 1'b0);
        check("t5_drain_halted", halted, 1'b0);
        tick();
        fu_done = 4'b1000;
        #1;
        check("t5_lsu_ack", fu_ack, 4'b1000);
        check("t5_lsu_rd", wb_rd, 5'd12);
        check("t5_halted_pre", halted, 1'b0);
        tick();
        fu_done = 4'b0000;
        #1;
        check("t5_halted", halted, 1'b1);
        check("t5_state_halted", dut.state, ST_HALTED);
        check("t5_halted_ready", issue_ready, 1'b0);
        tick();
        check("t5_halted_ready2", issue_ready, 1'b0);
        check("t5_halted2", halted, 1'b1);

        do_reset();

        // 6: flush, then async reset in the middle of a DIV
        check("t6_halted_cleared", halted, 1'b0);
        check("t6_state_run", dut.state, ST_RUN);
        drive(1'b1, FU_ARITH, 5'd0, 5'd0, 5'd14, 1'b1);
        flush = 1'b1;
        #1;
        check("t6_flush_block", issue_ready, 1'b0);
        flush = 1'b0;
        #1;
        check("t6_noflush_ready", issue_ready, 1'b1);
        check("t6_arith_start", fu_start, 4'b0001);
        tick();
        fu_done = 4'b0001;
        drive(1'b1, FU_DIV, 5'd0, 5'd0, 5'd13, 1'b1);
        #1;
        check("t6_arith_ack", fu_ack, 4'b0001);
        check("t6_div_start", fu_start, 4'b0100);
        tick();
        issue_valid = 1'b0;
        fu_done     = 4'b0000;
        #1;
        check("t6_pre_ptr", dut.rr_ptr, 2'd1);
        check("t6_pre_busy", dut.fu_busy, 4'b0100);
        check("t6_pre_regs", dut.reg_busy, 32'h0000_2000);
        #1;
        nRST = 1'b0;
        #1;
        check("t6_async_busy", dut.fu_busy, 4'b0000);
        check("t6_async_regs", dut.reg_busy, 32'h0);
        check("t6_async_ptr", dut.rr_ptr, 2'd0);
        check("t6_async_halted", halted, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        drive(1'b1, FU_ARITH, 5'd13, 5'd0, 5'd13, 1'b1);
        #1;
        check("t6_post_ready", issue_ready, 1'b1);
        check("t6_post_start", fu_start, 4'b0001);
        tick();
        issue_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
- Issue-side scheduler for the multi-unit scalar execute stage.
- Takes the decoded instruction from the control unit: FU type, rs1/rs2/rd, wen.
- Holds the instruction until it is free of RAW and WAW hazards and its functional unit is idle, then pulses a start to that unit.
- Arbitrates the single register-file writeback port among completing units (ARITH, MULT, DIV, LSU) with round-robin priority.
- Provides a halt-drain sequence.

Parameters:
- NUM_FU, 4, number of writeback-capable functional units (0=ARITH, 1=MULT, 2=DIV, 3=LSU).
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- issue_valid  in  1  decoded instruction present
- issue_fu  in  2  target FU index (fu_idx_t)
- issue_rs1  in  5  source 1
- issue_rs2  in  5  source 2
- issue_rd  in  5  destination
- issue_wen  in  1  instruction writes rd
- issue_ready  out  1  instruction accepted this cycle
- flush  in  1  suppress issue this cycle
- halt_req  in  1  halt instruction decoded
- fu_start  out  NUM_FU  one-hot start pulse
- fu_done  in  NUM_FU  unit has a result; held until acked
- fu_ack  out  NUM_FU  one-hot writeback grant
- wb_valid  out  1  register-file write this cycle
- wb_rd  out  5  writeback destination
- wb_fu  out  2  granted FU index (result mux select)
- halted  out  1  core drained and halted

Behaviour:
- State registers:
  - reg_busy[NUM_REGS-1:0]
  - fu_busy[NUM_FU-1:0]
  - fu_rd[NUM_FU][4:0]
  - fu_wen[NUM_FU]
  - rr_ptr[1:0]
  - state
- Reset (async, nRST low): all of the above clear to 0; state=RUN; halted=0.
- Combinational outputs with all-zero state: issue_ready=0 unless issue_valid, fu_start=0, fu_ack=0, wb_valid=0.
- Writeback arbitration (combinational, same cycle):
  - Candidates are fu_done & fu_busy.
  - Search starts at rr_ptr and wraps modulo NUM_FU; at most one fu_ack.
  - On grant g: wb_valid=fu_wen[g] and (fu_rd[g]!=0); wb_rd=fu_rd[g]; wb_fu=g.
  - At the clock edge: fu_busy[g] clears, reg_busy[fu_rd[g]] clears, rr_ptr=(g+1) mod NUM_FU.
  - With no grant, rr_ptr holds.
  - fu_done on an idle FU is ignored and never acked.
- Hazard check uses next-state busy, i.e. busy bits after this cycle's grant clears (clear-before-check):
  - raw: reg_busy'[rs1] (rs1!=0) or reg_busy'[rs2] (rs2!=0)
  - waw: issue_wen and rd!=0 and reg_busy'[rd]
  - fu_hold: fu_busy'[issue_fu]
- issue_ready = issue_valid & ~flush & state==RUN & ~raw & ~waw & ~fu_hold.
- On issue:
  - fu_start[issue_fu]=1 for exactly that cycle.
  - At the edge: fu_busy set, fu_rd/fu_wen captured, reg_busy[rd] set if wen and rd!=0.
  - Set has priority over clear for the same bit; this only occurs via a same-cycle grant and issue to the same FU/rd, which is legal.
- Stalled instruction: the upstream holds issue_* stable until issue_ready.
- x0: reg_busy[0] is never set and reads as 0.
- Halt FSM (2-bit):
  - RUN: if halt_req & issue_valid, go to DRAIN; the halt itself is never issued.
  - DRAIN: issue blocked; when fu_busy'==0, go to HALTED.
  - HALTED: halted=1; issue blocked; only nRST exits.
- flush:
  - Only blocks issue for the current cycle.
  - In-flight ops are older than the flush point and complete and write back normally.
  - flush in DRAIN/HALTED has no effect.
- Reset mid-operation discards all tracking. FUs are reset by the same nRST, so no orphan fu_done arrives.

Decomposition:
- Shared package (rv32i_types_pkg or a new scheduler_pkg):
  - fu_idx_t enum: FU_ARITH=0, FU_MULT=1, FU_DIV=2, FU_LSU=3
  - sched_state_t enum: RUN, DRAIN, HALTED
  - NUM_FU constant
- Sub-module rr_arbiter (parameterised N, inputs req/ptr, output one-hot grant + index) is natural and reusable.

Test Plan:
1. RAW stall: issue DIV rd=5; next cycle issue ARITH rs1=5. Required: issue_ready=0 until the DIV fu_done is acked; ARITH issues in that same ack cycle (clear-before-check).
2. Round-robin contention, rr_ptr=0: MULT, DIV and LSU hold fu_done simultaneously. Required: acks in order MULT, DIV, LSU on consecutive cycles; wb_rd matches each captured rd; rr_ptr ends at 0.
3. x0 and no-wen: MULT rd=0, then ARITH rs1=0 rs2=0. Required: no stall; wb_valid=0 on the MULT ack; reg_busy stays all-zero.
4. Structural plus same-FU turnover: second MULT while the first is busy stalls; on the first MULT's ack cycle the second issues. Required: fu_start[1] in that cycle; fu_busy[1] remains 1; new rd is busy.
5. Halt drain: LSU in flight, halt_req with issue_valid. Required: state DRAIN, issue_ready=0; halted=1 the cycle after the LSU ack; later issue_valid stays blocked.
6. Async reset mid-DIV (nRST low between edges). Required: fu_busy, reg_busy and rr_ptr are 0 immediately and halted=0; after release an ARITH using the old rd issues with no stall.
